// File: rtl/router_pkt_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Holds the FSM state encoding, field widths and the header packer.
package router_pkt_pkg;

    localparam int LEN_W = 6;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    function automatic logic [7:0] pack_header(
        input logic [LEN_W-1:0] len,
        input logic [1:0]       addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: DEPTH x 8 registers, synchronous write, async read.
// Ports: clock, we/waddr/wdata (write), raddr -> rdata (read).
module router_tx_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: loads a payload from an upstream byte
// source, then sends header, payload and XOR parity to the router.
// Ports: clock/resetn; start+dest_addr+pay_len+corrupt_parity request;
// src_valid/src_data/src_ready upstream; busy stall; pkt_valid/pkt_data
// router side; tx_active, done, start_err status.
module router_pkt_tx
    import router_pkt_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int BUF_DEPTH  = 64
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       dest_addr,
    input  logic [LEN_W-1:0] pay_len,
    input  logic             corrupt_parity,
    input  logic             src_valid,
    input  logic [7:0]       src_data,
    output logic             src_ready,
    input  logic             busy,
    output logic             pkt_valid,
    output logic [7:0]       pkt_data,
    output logic             tx_active,
    output logic             done,
    output logic             start_err
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       addr_q, addr_d;
    logic             corrupt_q, corrupt_d;
    logic [7:0]       parity_q, parity_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             valid_d;
    logic [7:0]       data_d;
    logic             active_d;
    logic             done_d;
    logic             err_d;
    logic             we;
    logic [AW-1:0]    ptr;
    logic [7:0]       rdata;

    // One counter serves as write pointer in LOAD and as the index of
    // the next payload byte to present in HEADER/PAYLOAD.
    assign ptr = AW'(cnt_q);

    assign src_ready = (state_q == S_LOAD) && (cnt_q != len_q);

    router_tx_buf #(
        .DEPTH (BUF_DEPTH),
        .AW    (AW)
    ) u_buf (
        .clock (clock),
        .we    (we),
        .waddr (ptr),
        .wdata (src_data),
        .raddr (ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            corrupt_q <= 1'b0;
            parity_q  <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            corrupt_q <= corrupt_d;
            parity_q  <= parity_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            pkt_valid <= valid_d;
            pkt_data  <= data_d;
            tx_active <= active_d;
            done      <= done_d;
            start_err <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        corrupt_d = corrupt_q;
        parity_d  = parity_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        valid_d   = pkt_valid;
        data_d    = pkt_data;
        active_d  = tx_active;
        done_d    = 1'b0;
        err_d     = 1'b0;
        we        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (pay_len == '0 || dest_addr == ADDR_INVALID) begin
                        err_d = 1'b1;
                    end else begin
                        len_d     = pay_len;
                        addr_d    = dest_addr;
                        corrupt_d = corrupt_parity;
                        parity_d  = pack_header(pay_len, dest_addr);
                        cnt_d     = '0;
                        active_d  = 1'b1;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (src_valid && src_ready) begin
                    we       = 1'b1;
                    parity_d = parity_q ^ src_data;
                    if (cnt_q == len_q - 6'd1) begin
                        // Header goes out registered on the same edge
                        // that takes the last payload byte.
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        data_d  = pack_header(len_q, addr_q);
                        state_d = S_HEADER;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    data_d  = rdata;
                    cnt_d   = 6'd1;
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    if (cnt_q == len_q) begin
                        valid_d = 1'b0;
                        data_d  = corrupt_q ? ~parity_q : parity_q;
                        state_d = S_PARITY;
                    end else begin
                        data_d = rdata;
                        cnt_d  = cnt_q + 6'd1;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    data_d  = '0;
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected byte stream is queued
// when a packet is issued and popped by a monitor on each transfer.
module tb_router_pkt_tx;

    localparam int GAP = 2;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic       corrupt_parity;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       tx_active;
    logic       done;
    logic       start_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t       q[$];
    logic [7:0] pay[$];

    router_pkt_tx #(
        .GAP_CYCLES (GAP),
        .BUF_DEPTH  (64)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .dest_addr      (dest_addr),
        .pay_len        (pay_len),
        .corrupt_parity (corrupt_parity),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .busy           (busy),
        .pkt_valid      (pkt_valid),
        .pkt_data       (pkt_data),
        .tx_active      (tx_active),
        .done           (done),
        .start_err      (start_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: values seen at a negedge are what the next rising edge
    // samples, so busy=0 here means a transfer happens on that edge.
    logic       in_pkt = 1'b0;
    logic       hold = 1'b0;
    logic       exp_done = 1'b0;
    logic       hv;
    logic [7:0] hd;
    exp_t       e;

    always @(negedge clock) begin
        if (!resetn) begin
            in_pkt   = 1'b0;
            hold     = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (exp_done || done) chk("done_pulse", done, exp_done);
            exp_done = 1'b0;
            if (hold) begin
                chk("hold_valid", pkt_valid, hv);
                chk("hold_data", pkt_data, hd);
            end
            hold = 1'b0;
            if (pkt_valid || in_pkt) begin
                if (busy) begin
                    hold = 1'b1;
                    hv   = pkt_valid;
                    hd   = pkt_data;
                end else begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got %0h with empty queue",
                                 pkt_data);
                    end else begin
                        e = q.pop_front();
                        chk("xfer_data", pkt_data, e.data);
                        chk("xfer_valid", pkt_valid, e.valid);
                    end
                    in_pkt   = pkt_valid;
                    exp_done = !pkt_valid;
                end
            end
        end
    end

    // Reference model: header = len*4+addr, parity = XOR of header and
    // payload, inverted on request; header/payload valid, parity not.
    task automatic issue_start(input int len, input int addr,
                               input bit corrupt, input bit fixed,
                               output int t);
        logic [7:0] h;
        logic [7:0] par;
        pay.delete();
        for (int i = 0; i < len; i++)
            pay.push_back(fixed ? 8'((i + 1) * 17) : 8'($urandom));
        h   = 8'(len * 4 + addr);
        par = h;
        foreach (pay[i]) par = par ^ pay[i];
        if (corrupt) par = ~par;
        q.push_back(exp_t'{1'b1, h});
        foreach (pay[i]) q.push_back(exp_t'{1'b1, pay[i]});
        q.push_back(exp_t'{1'b0, par});
        @(posedge clock); #1;
        start          = 1'b1;
        pay_len        = 6'(len);
        dest_addr      = 2'(addr);
        corrupt_parity = corrupt;
        t = cyc + 1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("tx_active_on", tx_active, 1);
    endtask

    task automatic feed(input int len, input int mode, output int last);
        int   idx;
        logic v;
        idx  = 0;
        last = -1;
        for (int k = 0; k < 1000 && idx < len; k++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 1);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            src_valid = v;
            src_data  = v ? pay[idx] : 8'($urandom);
            @(negedge clock);
            chk("src_ready_load", src_ready, 1);
            if (v && src_ready) begin
                idx++;
                last = cyc + 1;
            end
            @(posedge clock); #1;
        end
        src_valid = 1'b0;
        if (idx < len) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got %0d bytes expected %0d", idx, len);
        end
        @(negedge clock);
        chk("src_ready_drop", src_ready, 0);
    endtask

    task automatic run_out(input int bmode, input int poke_k, output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = -1;
        for (int k = 1; k < 400 && !seen; k++) begin
            @(posedge clock); #1;
            case (bmode)
                0:       busy = 1'b0;
                1:       busy = (k >= 1 && k <= 3) || (k >= 12 && k <= 13);
                default: busy = ($urandom_range(0, 3) == 0);
            endcase
            if (k == poke_k) begin
                start     = 1'b1;
                pay_len   = 6'd5;
                dest_addr = 2'd0;
            end
            if (k == poke_k + 1) start = 1'b0;
            @(negedge clock);
            if (k == poke_k + 1) chk("poke_no_err", start_err, 0);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        busy  = 1'b0;
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected one");
        end else begin
            repeat (GAP - 1) @(negedge clock);
            chk("tx_active_gap", tx_active, 1);
            @(negedge clock);
            chk("tx_active_end", tx_active, 0);
        end
    endtask

    initial begin
        int t, la, d, ln;
        resetn = 0; start = 0; dest_addr = 0; pay_len = 0;
        corrupt_parity = 0; src_valid = 0; src_data = 0; busy = 0;
        repeat (2) @(negedge clock);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_pkt_data", pkt_data, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_done", done, 0);
        chk("rst_start_err", start_err, 0);
        @(posedge clock); #3 resetn = 1;

        // len=3 addr=1, bytes 11/22/33, no stalls
        issue_start(3, 1, 0, 1, t);
        feed(3, 0, la);
        chk("t1_load_end", la, t + 3);
        run_out(0, 0, d);
        chk("t1_done_lat", d, t + 8);

        // same packet, corrupted parity, start poked during PAYLOAD
        issue_start(3, 1, 1, 1, t);
        feed(3, 0, la);
        run_out(0, 3, d);
        chk("t2_done_lat", d, t + 8);

        // len=20 addr=0 with scripted busy stalls
        issue_start(20, 0, 0, 0, t);
        feed(20, 0, la);
        run_out(1, 0, d);
        chk("t3_done_lat", d, t + 42 + 5);

        // len=63 addr=2, src_valid every other cycle
        issue_start(63, 2, 0, 0, t);
        feed(63, 1, la);
        chk("t4_load_len", la, t + 126);
        run_out(0, 0, d);
        chk("t4_done_lat", d, la + 63 + 2);

        // rejected starts
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            start     = 1'b1;
            pay_len   = (i == 0) ? 6'd0 : 6'd5;
            dest_addr = (i == 0) ? 2'd1 : 2'd3;
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock);
            chk("start_err_pulse", start_err, 1);
            chk("start_err_idle", tx_active, 0);
            chk("start_err_pv", pkt_valid, 0);
            @(negedge clock);
            chk("start_err_clear", start_err, 0);
            chk("start_err_idle2", tx_active, 0);
        end

        // reset in the middle of PAYLOAD
        issue_start(10, 1, 0, 0, t);
        feed(10, 0, la);
        repeat (5) @(posedge clock);
        #3 resetn = 0;
        #1;
        chk("arst_pkt_valid", pkt_valid, 0);
        chk("arst_pkt_data", pkt_data, 0);
        chk("arst_tx_active", tx_active, 0);
        q.delete();
        repeat (2) @(posedge clock);
        #3 resetn = 1;
        issue_start(5, 1, 0, 0, t);
        feed(5, 0, la);
        run_out(0, 0, d);
        chk("t6_done_lat", d, t + 12);

        // randomized packets with random source gaps and busy
        for (int n = 0; n < 5; n++) begin
            ln = $urandom_range(1, 63);
            issue_start(ln, $urandom_range(0, 2), 1'($urandom), 0, t);
            feed(ln, 2, la);
            run_out(2, 0, d);
        end

        repeat (5) @(negedge clock);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
